spi_adc_scan: RTL and testbench
===============================

// Module: spi_adc_scan
// PURPOSE
//  Multi-channel SAR ADC scan engine: next generation of the single-channel SPI ADC core.
//  Steps an external analog mux through the channels enabled in a mask, runs one SAR conversion per channel,
//  and buffers the results in a FIFO that the SPI register slave drains.
//  Timing comes from a clock-enable tick derived from sys_clk; the block has no derived clock domain.
//  Raises a level-interrupt when FIFO fill reaches a threshold, or on overflow.
// PARAMETERS
//  ADC_WIDTH     12  SAR resolution in bits (4..16)
//  NUM_CH        8   analog channels (2..16); CH_W = $clog2(NUM_CH)
//  FIFO_DEPTH    16  result FIFO entries, power of 2; LVL_W = $clog2(FIFO_DEPTH)+1
//  TICK_DIV      223 sys_clk cycles per SAR tick (>=2)
//  SETTLE_TICKS  2   mux settle ticks after channel switch (>=1)
//  SAMPLE_TICKS  2   sample_and_hold high ticks (>=1)
// PORTS
//  sys_clk     in   1          system clock
//  reset_      in   1          asynchronous, active-low reset
//  en          in   1          global enable; low aborts and holds engine in IDLE
//  start       in   1          single-cycle pulse: one scan pass
//  auto_mode   in   1          continuous scanning while high
//  ch_mask     in   NUM_CH     bit i=1 -> channel i included in scan
//  comparator  in   1          1 = Vin >= DAC
//  ch_sel      out  CH_W       analog mux select
//  dac         out  ADC_WIDTH  DAC code
//  sample_and_hold out 1       high during sampling
//  dac_rst     out  1          high during SETTLE
//  busy        out  1          engine not IDLE
//  scan_done   out  1          1-cycle pulse at end of each pass
//  fifo_rd     in   1          pop request
//  fifo_rdata  out  DW         head word (first-word-fall-through)
//  fifo_empty  out  1          FIFO empty
//  fifo_level  out  LVL_W      entries held
//  flush       in   1          empty FIFO, clear overflow
//  irq_thresh  in   LVL_W      interrupt fill threshold
//  int_en      in   1          interrupt enable
//  overflow    out  1          sticky: sample dropped
//  irq         out  1          level interrupt
// BEHAVIOUR
//  Reset: all outputs 0, fifo_empty=1, FSM IDLE, tick counter 0, FIFO empty.
//  tick: 1-cycle strobe every TICK_DIV sys_clk cycles; counter free-runs while en=1, held at 0 while en=0.
//  FSM (all states except IDLE/STORE advance on tick):
//   IDLE: leave when en & |ch_mask & (start | auto_mode); latch mask; ch_sel = lowest set bit.
//         Otherwise stay; start is ignored when ch_mask=0.
//   SETTLE: dac_rst=1, dac=0; SETTLE_TICKS ticks.
//   SAMPLE: sample_and_hold=1; SAMPLE_TICKS ticks.
//   CONVERT: entry dac = 1<<(ADC_WIDTH-1). Each tick resolves bit k = ADC_WIDTH-1..0:
//            clear bit k if comparator=0, then set bit k-1 (if k>0). ADC_WIDTH ticks total.
//   STORE: one sys_clk cycle; push final dac code to FIFO.
//          Next latched channel above the current one -> SETTLE with ch_sel updated.
//          Otherwise scan_done=1, then SETTLE on the first channel if auto_mode=1, else IDLE.
//  Latency per channel: SETTLE_TICKS + SAMPLE_TICKS + ADC_WIDTH ticks, plus 1 cycle.
//  Mask changes take effect only at pass start.
//  en=0 mid-scan: next cycle -> IDLE, outputs cleared, no partial word written; FIFO contents kept.
//  FIFO push when full: word dropped, overflow=1.
//  FIFO push and pop in the same cycle: both happen, level unchanged; full+pop+push is not an overflow.
//  Pop when empty: ignored, fifo_rdata holds its value.
//  Pointers wrap modulo FIFO_DEPTH.
//  flush: FIFO empty and overflow=0 next cycle; a simultaneous push is discarded without setting overflow.
//  irq = int_en & ((fifo_level >= irq_thresh & irq_thresh != 0) | overflow); registered, 1-cycle latency.
// CONFIGURATION
//  SPI_ADC_SCAN_TAG_EN defined: DW = ADC_WIDTH+CH_W, fifo_rdata = {channel, code}.
//  Undefined: DW = ADC_WIDTH, code only; the reader infers channel from mask order.
// TESTING
//  1. TICK_DIV=4, ch_mask=8'h05, comparator models Vin=12'hA5C, start pulse
//     -> 2 FIFO words 12'hA5C (ch0, ch2), scan_done once, busy falls, IDLE.
//  2. auto_mode=1, ch_mask=8'h80
//     -> repeated ch7 conversions, ch_sel stays 7; drop auto_mode -> stops after current pass.
//  3. FIFO_DEPTH=4, no reads, 5 conversions -> fifo_level=4, overflow=1, irq=1 with int_en=1;
//     flush -> level 0, irq 0.
//  4. en=0 during CONVERT of ch1 -> next cycle IDLE, dac=0, fifo_level unchanged.
//  5. FIFO full, fifo_rd coincident with push -> level stays 4, overflow stays 0, order preserved.
//  6. ch_mask=0 plus start -> busy stays 0; irq_thresh=2, int_en=1 -> irq rises the cycle after the 2nd push.

Source files
------------

// File: rtl/spi_adc_scan_if.sv
// spi_adc_scan_if: signal bundle between the scan engine and its host/analog front end
//   slave  : engine side (control/analog/FIFO inputs in, mux/DAC/status/FIFO outputs out)
//   master : host and analog front-end side (mirror of slave)
//   SPI_ADC_SCAN_TAG_EN defined: fifo_rdata = {channel, code}; otherwise code only
interface spi_adc_scan_if #(
    parameter int ADC_WIDTH  = 12,
    parameter int NUM_CH     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
`ifdef SPI_ADC_SCAN_TAG_EN
    localparam int DW = ADC_WIDTH + CH_W;
`else
    localparam int DW = ADC_WIDTH;
`endif
    logic              en, start, auto_mode, comparator;
    logic [NUM_CH-1:0] ch_mask;
    logic [CH_W-1:0]   ch_sel;
    logic [ADC_WIDTH-1:0] dac;
    logic              sample_and_hold, dac_rst, busy, scan_done;
    logic              fifo_rd, fifo_empty, flush, int_en, overflow, irq;
    logic [DW-1:0]     fifo_rdata;
    logic [LVL_W-1:0]  fifo_level, irq_thresh;
    modport slave (
        input  en, start, auto_mode, ch_mask, comparator, fifo_rd, flush, irq_thresh, int_en,
        output ch_sel, dac, sample_and_hold, dac_rst, busy, scan_done,
        output fifo_rdata, fifo_empty, fifo_level, overflow, irq
    );
    modport master (
        output en, start, auto_mode, ch_mask, comparator, fifo_rd, flush, irq_thresh, int_en,
        input  ch_sel, dac, sample_and_hold, dac_rst, busy, scan_done,
        input  fifo_rdata, fifo_empty, fifo_level, overflow, irq
    );
endinterface

// File: rtl/spi_adc_scan.sv
// spi_adc_scan: multi-channel SAR ADC scan engine with result FIFO and level interrupt
//   sys_clk, reset_ (async, active-low)
//   bus (spi_adc_scan_if.slave): en/start/auto_mode/ch_mask control, comparator in,
//     ch_sel/dac/sample_and_hold/dac_rst analog controls, busy/scan_done status,
//     fifo_rd/flush/fifo_rdata/fifo_empty/fifo_level FIFO port, irq_thresh/int_en/overflow/irq
//   SPI_ADC_SCAN_TAG_EN defined: FIFO words carry {channel, code}
module spi_adc_scan #(
    parameter int ADC_WIDTH    = 12,
    parameter int NUM_CH       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int TICK_DIV     = 223,
    parameter int SETTLE_TICKS = 2,
    parameter int SAMPLE_TICKS = 2
) (
    input logic sys_clk,
    input logic reset_,
    spi_adc_scan_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PW    = LVL_W - 1;
    localparam int TDW   = $clog2(TICK_DIV);
    localparam int TW    = $clog2(SETTLE_TICKS + SAMPLE_TICKS + 1);
`ifdef SPI_ADC_SCAN_TAG_EN
    localparam int DW = ADC_WIDTH + CH_W;
`else
    localparam int DW = ADC_WIDTH;
`endif
    localparam logic [ADC_WIDTH-1:0] MSB = {1'b1, {(ADC_WIDTH-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, CONVERT, STORE} state_t;
    state_t state;
    logic [TDW-1:0] div_cnt;
    logic [TW-1:0] tcnt;
    logic [ADC_WIDTH-1:0] bit_m;
    logic [NUM_CH-1:0] mask;
    logic [CH_W-1:0] first_ch, next_ch;
    logic has_next, tick, push, pop, wr, full;
    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [DW-1:0] word;
    logic [PW-1:0] wp, rp;
    assign tick = bus.en && div_cnt == TDW'(TICK_DIV - 1);
    always_ff @(posedge sys_clk or negedge reset_)
        if (!reset_) div_cnt <= '0;
        else div_cnt <= (!bus.en || tick) ? '0 : div_cnt + 1'b1;
    // first_ch: lowest channel of the live mask (pass start); next_ch: next latched channel above ch_sel
    always_comb begin
        first_ch = '0;
        next_ch = '0;
        has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (bus.ch_mask[i]) first_ch = CH_W'(i);
            if (mask[i] && CH_W'(i) > bus.ch_sel) begin
                next_ch = CH_W'(i);
                has_next = 1'b1;
            end
        end
    end
    always_ff @(posedge sys_clk or negedge reset_)
        if (!reset_) begin
            state <= IDLE;
            {tcnt, bit_m, mask, bus.ch_sel, bus.dac} <= '0;
            {bus.sample_and_hold, bus.dac_rst, bus.busy, bus.scan_done} <= '0;
        end else if (!bus.en) begin
            state <= IDLE;
            {tcnt, bus.ch_sel, bus.dac} <= '0;
            {bus.sample_and_hold, bus.dac_rst, bus.busy, bus.scan_done} <= '0;
        end else begin
            bus.scan_done <= 1'b0;
            case (state)
                IDLE: if (|bus.ch_mask && (bus.start || bus.auto_mode)) begin
                    mask <= bus.ch_mask;
                    bus.ch_sel <= first_ch;
                    {state, tcnt, bus.dac, bus.dac_rst, bus.busy} <= {SETTLE, TW'(0), ADC_WIDTH'(0), 2'b11};
                end
                SETTLE: if (tick) begin
                    if (tcnt == TW'(SETTLE_TICKS - 1))
                        {state, tcnt, bus.dac_rst, bus.sample_and_hold} <= {SAMPLE, TW'(0), 2'b01};
                    else tcnt <= tcnt + 1'b1;
                end
                SAMPLE: if (tick) begin
                    if (tcnt == TW'(SAMPLE_TICKS - 1))
                        {state, bus.sample_and_hold, bus.dac, bit_m} <= {CONVERT, 1'b0, MSB, MSB};
                    else tcnt <= tcnt + 1'b1;
                end
                // bit_m marks the bit under trial; keep it if Vin >= DAC, then try the next lower one
                CONVERT: if (tick) begin
                    bus.dac <= (bus.comparator ? bus.dac : bus.dac & ~bit_m) | (bit_m >> 1);
                    bit_m <= bit_m >> 1;
                    if (bit_m[0]) state <= STORE;
                end
                STORE: begin
                    if (has_next) begin
                        bus.ch_sel <= next_ch;
                        {state, tcnt, bus.dac, bus.dac_rst} <= {SETTLE, TW'(0), ADC_WIDTH'(0), 1'b1};
                    end else begin
                        bus.scan_done <= 1'b1;
                        if (bus.auto_mode && |bus.ch_mask) begin
                            mask <= bus.ch_mask;
                            bus.ch_sel <= first_ch;
                            {state, tcnt, bus.dac, bus.dac_rst} <= {SETTLE, TW'(0), ADC_WIDTH'(0), 1'b1};
                        end else begin
                            state <= IDLE;
                            {bus.ch_sel, bus.dac, bus.busy} <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
`ifdef SPI_ADC_SCAN_TAG_EN
    assign word = {bus.ch_sel, bus.dac};
`else
    assign word = bus.dac;
`endif
    assign push = state == STORE && bus.en && !bus.flush;
    assign full = bus.fifo_level == LVL_W'(FIFO_DEPTH);
    assign pop = bus.fifo_rd && !bus.fifo_empty;
    // a pop frees the slot the coincident push lands in, so full+pop+push is not an overflow
    assign wr = push && (!full || pop);
    assign bus.fifo_empty = bus.fifo_level == '0;
    assign bus.fifo_rdata = mem[rp];
    always_ff @(posedge sys_clk or negedge reset_)
        if (!reset_) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            {wp, rp, bus.fifo_level, bus.overflow, bus.irq} <= '0;
        end else begin
            bus.irq <= bus.int_en && ((bus.fifo_level >= bus.irq_thresh && bus.irq_thresh != '0) || bus.overflow);
            if (bus.flush) {wp, rp, bus.fifo_level, bus.overflow} <= '0;
            else begin
                if (pop) rp <= rp + 1'b1;
                if (wr) begin
                    mem[wp] <= word;
                    wp <= wp + 1'b1;
                end
                if (push && !wr) bus.overflow <= 1'b1;
                bus.fifo_level <= bus.fifo_level + LVL_W'(wr) - LVL_W'(pop);
            end
        end
endmodule

// File: tb/tb_spi_adc_scan.sv
// tb_spi_adc_scan: directed bench for spi_adc_scan with a schedule-level reference model
`timescale 1ns/1ps
module tb_spi_adc_scan;
    localparam int AW = 12, NCH = 8, DEPTH = 4, TDIV = 4, ST = 2, SP = 2;
    localparam int CHW = 3, L = ST + SP + AW;
`ifdef SPI_ADC_SCAN_TAG_EN
    localparam int DW = AW + CHW;
`else
    localparam int DW = AW;
`endif
    logic sys_clk = 1'b0;
    logic reset_ = 1'b0;
    logic [AW-1:0] vin = '0;
    int vectors = 0, misses = 0, done_cnt = 0, prev;
    logic [DW-1:0] q[$];
    int m_list[$];
    bit m_busy, m_store, m_done, m_ovf, m_irq;
    int m_tc, m_e, m_cur;
    logic [DW-1:0] exp5 [4];
    bit hit;

    spi_adc_scan_if #(.ADC_WIDTH(AW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) bus ();
    spi_adc_scan #(.ADC_WIDTH(AW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .TICK_DIV(TDIV),
                   .SETTLE_TICKS(ST), .SAMPLE_TICKS(SP))
        dut (.sys_clk(sys_clk), .reset_(reset_), .bus(bus));

    always #5 sys_clk = ~sys_clk;
    assign bus.comparator = vin >= bus.dac;

    function automatic logic [DW-1:0] word(int ch, logic [AW-1:0] v);
`ifdef SPI_ADC_SCAN_TAG_EN
        return {CHW'(ch), v};
`else
        return (ch >= 0) ? v : '0;
`endif
    endfunction

    // Expected DAC code: after j resolved bits the top j bits equal Vin and bit AW-1-j is on trial
    function automatic int exp_dac();
        int v = int'(vin);
        int j;
        if (!m_busy || (!m_store && m_e < ST + SP)) return 0;
        if (m_store) return v;
        j = m_e - ST - SP;
        return ((v >> (AW - j)) << (AW - j)) | (1 << (AW - 1 - j));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_pass();
        m_list.delete();
        for (int i = 0; i < NCH; i++) if (bus.ch_mask[i]) m_list.push_back(i);
        m_cur = m_list.pop_front();
        m_e = 0;
    endtask

    // Model: a pass is a list of channels, each taking L ticks then one store cycle
    task automatic model_step();
        bit tick_now = bus.en && m_tc == TDIV - 1;
        bit do_push = bus.en && m_store;
        bit do_pop = bus.fifo_rd && q.size() != 0;
        m_irq = bus.int_en && ((q.size() >= int'(bus.irq_thresh) && bus.irq_thresh != 0) || m_ovf);
        if (bus.flush) begin
            q.delete();
            m_ovf = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                if (q.size() < DEPTH) q.push_back(word(m_cur, vin));
                else m_ovf = 1;
            end
        end
        m_tc = (bus.en && m_tc != TDIV - 1) ? m_tc + 1 : 0;
        m_done = 0;
        if (!bus.en) begin
            m_busy = 0;
            m_store = 0;
        end else if (!m_busy) begin
            if (bus.ch_mask != 0 && (bus.start || bus.auto_mode)) begin
                load_pass();
                m_busy = 1;
            end
        end else if (m_store) begin
            m_store = 0;
            if (m_list.size() != 0) begin
                m_cur = m_list.pop_front();
                m_e = 0;
            end else begin
                m_done = 1;
                if (bus.auto_mode && bus.ch_mask != 0) load_pass();
                else m_busy = 0;
            end
        end else if (tick_now) begin
            m_e++;
            if (m_e == L) m_store = 1;
        end
    endtask

    initial forever begin
        @(posedge sys_clk);
        if (!reset_) begin
            q.delete();
            {m_busy, m_store, m_done, m_ovf, m_irq} = '0;
            m_tc = 0;
            m_e = 0;
            m_cur = 0;
        end else model_step();
    end

    initial forever begin
        @(negedge sys_clk);
        if (bus.scan_done) done_cnt++;
        if (reset_) begin
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("ch_sel", 32'(bus.ch_sel), m_busy ? 32'(m_cur) : 32'd0);
            chk("scan_done", 32'(bus.scan_done), 32'(m_done));
            chk("dac", 32'(bus.dac), 32'(exp_dac()));
            chk("dac_rst", 32'(bus.dac_rst), 32'(m_busy && !m_store && m_e < ST));
            chk("sample_and_hold", 32'(bus.sample_and_hold), 32'(m_busy && !m_store && m_e >= ST && m_e < ST + SP));
            chk("fifo_level", 32'(bus.fifo_level), 32'(q.size()));
            chk("fifo_empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
            if (q.size() != 0) chk("fifo_rdata", 32'(bus.fifo_rdata), 32'(q[0]));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("irq", 32'(bus.irq), 32'(m_irq));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(string name, int budget);
        for (int i = 0; i < budget; i++) begin
            if (!bus.busy) return;
            cyc(1);
        end
        chk({name, " timeout"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        cyc(1);
        bus.flush = 1'b0;
        cyc(1);
    endtask

    task automatic pop1();
        bus.fifo_rd = 1'b1;
        cyc(1);
        bus.fifo_rd = 1'b0;
    endtask

    initial begin
        {bus.en, bus.start, bus.auto_mode, bus.fifo_rd, bus.flush, bus.int_en} = '0;
        bus.ch_mask = '0;
        bus.irq_thresh = '0;
        cyc(3);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst dac", 32'(bus.dac), 32'd0);
        chk("rst fifo_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst fifo_level", 32'(bus.fifo_level), 32'd0);
        chk("rst fifo_rdata", 32'(bus.fifo_rdata), 32'd0);
        chk("rst irq", 32'(bus.irq), 32'd0);
        reset_ = 1'b1;
        bus.en = 1'b1;
        cyc(3);

        // 1: one pass over ch0 and ch2
        vin = 12'hA5C;
        bus.ch_mask = 8'h05;
        pulse_start();
        wait_idle("t1", 400);
        chk("t1 level", 32'(bus.fifo_level), 32'd2);
        chk("t1 word0", 32'(bus.fifo_rdata), 32'(word(0, 12'hA5C)));
        chk("t1 scan_done count", 32'(done_cnt), 32'd1);
        pop1();
        chk("t1 word1", 32'(bus.fifo_rdata), 32'(word(2, 12'hA5C)));
        pop1();
        chk("t1 empty", 32'(bus.fifo_empty), 32'd1);

        // 2: continuous scanning of ch7, drained as it goes
        vin = 12'h123;
        bus.ch_mask = 8'h80;
        bus.fifo_rd = 1'b1;
        bus.auto_mode = 1'b1;
        prev = done_cnt;
        cyc(100);
        chk("t2 ch_sel", 32'(bus.ch_sel), 32'd7);
        cyc(120);
        chk("t2 repeated passes", 32'(done_cnt - prev >= 3), 32'd1);
        bus.auto_mode = 1'b0;
        wait_idle("t2", 200);
        cyc(2);
        bus.fifo_rd = 1'b0;
        chk("t2 stopped", 32'(bus.busy), 32'd0);
        do_flush();

        // 3: five conversions into a 4-deep FIFO
        vin = 12'h3C3;
        bus.ch_mask = 8'h1F;
        bus.int_en = 1'b1;
        pulse_start();
        wait_idle("t3", 600);
        chk("t3 level", 32'(bus.fifo_level), 32'd4);
        chk("t3 overflow", 32'(bus.overflow), 32'd1);
        cyc(1);
        chk("t3 irq", 32'(bus.irq), 32'd1);
        do_flush();
        chk("t3 flushed level", 32'(bus.fifo_level), 32'd0);
        chk("t3 irq cleared", 32'(bus.irq), 32'd0);

        // 6: empty mask ignores start; threshold interrupt at two entries
        bus.ch_mask = 8'h00;
        pulse_start();
        cyc(10);
        chk("t6 no start", 32'(bus.busy), 32'd0);
        bus.irq_thresh = 3'd2;
        vin = 12'h0FF;
        bus.ch_mask = 8'h03;
        pulse_start();
        wait_idle("t6", 400);
        cyc(1);
        chk("t6 irq", 32'(bus.irq), 32'd1);
        bus.int_en = 1'b0;
        do_flush();

        // 4: en dropped while converting ch1
        vin = 12'h555;
        pulse_start();
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            hit = bus.busy && bus.ch_sel == 1 && !bus.dac_rst && !bus.sample_and_hold;
            if (!hit) cyc(1);
        end
        chk("t4 reached convert", 32'(hit), 32'd1);
        cyc(3);
        bus.en = 1'b0;
        cyc(1);
        chk("t4 busy", 32'(bus.busy), 32'd0);
        chk("t4 dac", 32'(bus.dac), 32'd0);
        chk("t4 level", 32'(bus.fifo_level), 32'd1);
        cyc(2);
        bus.en = 1'b1;
        cyc(2);
        do_flush();

        // 5: full FIFO, pop coincident with push
        vin = 12'h111;
        bus.ch_mask = 8'h0F;
        pulse_start();
        wait_idle("t5 fill", 500);
        chk("t5 full", 32'(bus.fifo_level), 32'd4);
        vin = 12'h222;
        bus.ch_mask = 8'h01;
        pulse_start();
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            hit = m_store;
            if (!hit) cyc(1);
        end
        chk("t5 reached store", 32'(hit), 32'd1);
        pop1();
        chk("t5 level", 32'(bus.fifo_level), 32'd4);
        chk("t5 overflow", 32'(bus.overflow), 32'd0);
        wait_idle("t5", 50);
        exp5[0] = word(1, 12'h111);
        exp5[1] = word(2, 12'h111);
        exp5[2] = word(3, 12'h111);
        exp5[3] = word(0, 12'h222);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t5 order %0d", i), 32'(bus.fifo_rdata), 32'(exp5[i]));
            pop1();
        end
        chk("t5 drained", 32'(bus.fifo_empty), 32'd1);
        pop1();
        chk("t5 pop empty level", 32'(bus.fifo_level), 32'd0);

        cyc(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied, %0d miscompares", vectors, misses);
        $fatal(1, "watchdog");
    end
endmodule
